// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: register index type,
// controller state encoding, the per-cycle control word, and the
// free-running control-word builder shared by the RUN and release paths.
package pipeline_hazard_ctrl_pkg;

  typedef logic [4:0] rv32i_reg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    MEM_STALL  = 2'd1,
    REDIR_WAIT = 2'd2
  } hazard_state_t;

  typedef struct packed {
    logic pc_load;
    logic if_id_load;
    logic id_ex_load;
    logic ex_mem_load;
    logic mem_wb_load;
    logic if_id_flush;
    logic id_ex_flush;
    logic pc_sel_redir;
  } hazard_ctrl_t;

  localparam hazard_ctrl_t CTRL_FROZEN = '0;
  localparam hazard_ctrl_t CTRL_RESET  = '{pc_load: 1'b1, if_id_load: 1'b1, id_ex_load: 1'b1,
                                          ex_mem_load: 1'b1, mem_wb_load: 1'b1,
                                          if_id_flush: 1'b1, id_ex_flush: 1'b1,
                                          pc_sel_redir: 1'b0};

  // Control word for a cycle where memory is not holding the pipe.
  // A redirect outranks the load-use bubble: the ID instruction is wrong-path.
  function automatic hazard_ctrl_t flow_ctrl(input logic redir, input logic load_use);
    hazard_ctrl_t c;
    c = '{pc_load: 1'b1, if_id_load: 1'b1, id_ex_load: 1'b1, ex_mem_load: 1'b1,
          mem_wb_load: 1'b1, if_id_flush: 1'b0, id_ex_flush: 1'b0, pc_sel_redir: 1'b0};
    if (redir) begin
      c.if_id_flush  = 1'b1;
      c.id_ex_flush  = 1'b1;
      c.pc_sel_redir = 1'b1;
    end else if (load_use) begin
      c.pc_load     = 1'b0;
      c.if_id_load  = 1'b0;
      c.id_ex_flush = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status in, stage load/flush controls
// and performance counters out.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  import pipeline_hazard_ctrl_pkg::*;

  rv32i_reg         id_rs1_i;
  rv32i_reg         id_rs2_i;
  logic             id_use_rs1_i;
  logic             id_use_rs2_i;
  rv32i_reg         ex_rd_i;
  logic             ex_mem_read_i;
  logic             ex_redirect_i;
  logic             imem_read_i;
  logic             imem_resp_i;
  logic             dmem_req_i;
  logic             dmem_resp_i;
  logic             pc_load_o;
  logic             if_id_load_o;
  logic             id_ex_load_o;
  logic             ex_mem_load_o;
  logic             mem_wb_load_o;
  logic             if_id_flush_o;
  logic             id_ex_flush_o;
  logic             pc_sel_redir_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i, ex_rd_i, ex_mem_read_i,
           ex_redirect_i, imem_read_i, imem_resp_i, dmem_req_i, dmem_resp_i,
    input  pc_load_o, if_id_load_o, id_ex_load_o, ex_mem_load_o, mem_wb_load_o,
           if_id_flush_o, id_ex_flush_o, pc_sel_redir_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i, ex_rd_i, ex_mem_read_i,
           ex_redirect_i, imem_read_i, imem_resp_i, dmem_req_i, dmem_resp_i,
    output pc_load_o, if_id_load_o, id_ex_load_o, ex_mem_load_o, mem_wb_load_o,
           if_id_flush_o, id_ex_flush_o, pc_sel_redir_o, stall_cnt_o, flush_cnt_o
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating event counter: counts up on inc, sticks at all-ones.
module hazard_sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // Count events, holding at the maximum value instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: drives PC and pipeline-register load/flush
// enables, resolving memory wait > EX redirect > load-use hazard, and keeps
// saturating stall/flush counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
);

  hazard_state_t state, state_nxt;
  logic          redir_pend, redir_pend_nxt;
  hazard_ctrl_t  ctrl;
  logic          stall_inc, flush_inc;

  logic imem_busy, dmem_busy, mem_busy, load_use, redir_any;

  assign imem_busy = hz.imem_read_i & ~hz.imem_resp_i;
  assign dmem_busy = hz.dmem_req_i & ~hz.dmem_resp_i;
  assign mem_busy  = imem_busy | dmem_busy;
  assign load_use  = hz.ex_mem_read_i && (hz.ex_rd_i != '0) &&
                     ((hz.id_use_rs1_i && (hz.id_rs1_i == hz.ex_rd_i)) ||
                      (hz.id_use_rs2_i && (hz.id_rs2_i == hz.ex_rd_i)));
  assign redir_any = redir_pend | hz.ex_redirect_i;

  // Next state, control word and counter events from state and current inputs.
  always_comb begin
    state_nxt      = state;
    redir_pend_nxt = redir_pend;
    ctrl           = CTRL_FROZEN;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;
    if (rst) begin
      ctrl           = CTRL_RESET;
      state_nxt      = RUN;
      redir_pend_nxt = 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (mem_busy) begin
            stall_inc      = 1'b1;
            state_nxt      = MEM_STALL;
            redir_pend_nxt = hz.ex_redirect_i;
          end else begin
            ctrl      = flow_ctrl(hz.ex_redirect_i, load_use);
            flush_inc = hz.ex_redirect_i;
            stall_inc = ~hz.ex_redirect_i & load_use;
          end
        end
        MEM_STALL: begin
          if (mem_busy) begin
            stall_inc      = 1'b1;
            redir_pend_nxt = redir_any;
            // A redirect is known while a fetch is in flight: that fetch is
            // wrong-path and must return before the PC may be retargeted.
            if (imem_busy && redir_any) begin
              state_nxt = REDIR_WAIT;
            end
          end else begin
            ctrl           = flow_ctrl(redir_any, load_use);
            flush_inc      = redir_any;
            stall_inc      = ~redir_any & load_use;
            redir_pend_nxt = 1'b0;
            state_nxt      = RUN;
          end
        end
        REDIR_WAIT: begin
          if (hz.imem_resp_i && !dmem_busy) begin
            ctrl           = flow_ctrl(1'b1, 1'b0);
            flush_inc      = 1'b1;
            redir_pend_nxt = 1'b0;
            state_nxt      = RUN;
          end else begin
            stall_inc = 1'b1;
          end
        end
        default: begin
          state_nxt      = RUN;
          redir_pend_nxt = 1'b0;
        end
      endcase
    end
  end

  // Controller state and pending-redirect flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      redir_pend <= 1'b0;
    end else begin
      state      <= state_nxt;
      redir_pend <= redir_pend_nxt;
    end
  end

  assign hz.pc_load_o      = ctrl.pc_load;
  assign hz.if_id_load_o   = ctrl.if_id_load;
  assign hz.id_ex_load_o   = ctrl.id_ex_load;
  assign hz.ex_mem_load_o  = ctrl.ex_mem_load;
  assign hz.mem_wb_load_o  = ctrl.mem_wb_load;
  assign hz.if_id_flush_o  = ctrl.if_id_flush;
  assign hz.id_ex_flush_o  = ctrl.id_ex_flush;
  assign hz.pc_sel_redir_o = ctrl.pc_sel_redir;

  hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .cnt (hz.stall_cnt_o)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_inc),
    .cnt (hz.flush_cnt_o)
  );

endmodule
